// File: rtl/lut_neuron_pkg.sv
// lut_neuron_pkg: shared FSM state type, address-width and parity helpers for the LUT neuron
package lut_neuron_pkg;
  typedef enum logic {INIT, RUN} fsm_state_t;
  function automatic int addr_w(input int fan_in, input int in_bits);
    return fan_in * in_bits;
  endfunction
  function automatic logic even_par(input logic [31:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/lut_neuron_tbl.sv
// lut_neuron_tbl: simple dual-port truth table, one write port and one registered read port
module lut_neuron_tbl #(
  parameter int ADDR_W = 8,
  parameter int WIDTH = 2
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);
  logic [WIDTH-1:0] r_mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/lut_neuron_stream.sv
// lut_neuron_stream: programmable LUT neuron with valid/ready streams and post-reset table clear.
// Build with LUT_PARITY_EN to store an even-parity bit per entry and flag read mismatches.
module lut_neuron_stream
  import lut_neuron_pkg::*;
#(
  parameter int FAN_IN = 4,
  parameter int IN_BITS = 2,
  parameter int OUT_BITS = 2,
  parameter logic [OUT_BITS-1:0] INIT_VAL = '0,
  localparam int ADDR_W = addr_w(FAN_IN, IN_BITS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [OUT_BITS-1:0] cfg_data,
  input  logic                cfg_perr_inj,
  output logic                init_busy,
  output logic                err_parity
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);
`ifdef LUT_PARITY_EN
  localparam int TW = OUT_BITS + 1;
`else
  localparam int TW = OUT_BITS;
`endif
  fsm_state_t r_state, w_state_nx;
  logic [ADDR_W:0] r_clr_cnt, w_clr_cnt_nx;
  logic r_s1_valid, r_s2_valid, r_err;
  logic [OUT_BITS-1:0] r_s2_data;
  logic w_init, w_adv1, w_adv2, w_accept, w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [TW-1:0] w_wdata, w_rdata;
  always_comb begin
    w_init = r_state == INIT;
    w_state_nx = (w_init && r_clr_cnt == LAST) ? RUN : r_state;
    w_clr_cnt_nx = w_init ? r_clr_cnt + 1'b1 : r_clr_cnt;
    w_adv2 = !r_s2_valid || out_ready;
    w_adv1 = !r_s1_valid || w_adv2;
    in_ready = !w_init && w_adv1;
    w_accept = in_valid && in_ready;
    w_we = w_init || cfg_we;
    w_waddr = w_init ? r_clr_cnt[ADDR_W-1:0] : cfg_addr;
`ifdef LUT_PARITY_EN
    w_wdata = w_init ? {even_par(32'(INIT_VAL)), INIT_VAL}
                     : {even_par(32'(cfg_data)) ^ cfg_perr_inj, cfg_data};
`else
    w_wdata = w_init ? INIT_VAL : cfg_data;
`endif
  end
`ifndef LUT_PARITY_EN
  logic w_unused;
  assign w_unused = cfg_perr_inj;
`endif
  // the table is read at accept so a same-cycle config write is seen only by later lookups
  lut_neuron_tbl #(.ADDR_W(ADDR_W), .WIDTH(TW)) u_tbl (
    .clk(clk), .i_we(w_we), .i_waddr(w_waddr), .i_wdata(w_wdata),
    .i_re(w_adv1), .i_raddr(in_data), .o_rdata(w_rdata)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nx;
      r_clr_cnt <= w_clr_cnt_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_data <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_adv1) r_s1_valid <= w_accept;
      if (w_adv2) begin
        r_s2_valid <= r_s1_valid;
        r_s2_data <= w_rdata[OUT_BITS-1:0];
      end
`ifdef LUT_PARITY_EN
      if (w_adv2 && r_s1_valid && even_par(32'(w_rdata[OUT_BITS-1:0])) != w_rdata[OUT_BITS])
        r_err <= 1'b1;
`endif
    end
  end
  assign out_valid = r_s2_valid;
  assign out_data = r_s2_data;
  assign init_busy = w_init;
  assign err_parity = r_err;
endmodule

// File: tb/tb_lut_neuron_stream.sv
// tb_lut_neuron_stream: scoreboard bench for lut_neuron_stream; parity scenario only with LUT_PARITY_EN
module tb_lut_neuron_stream;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic cfg_we = 0, cfg_perr_inj = 0, init_busy, err_parity;
  logic [7:0] in_data = 0, cfg_addr = 0;
  logic [1:0] out_data, cfg_data = 0;
  int errors = 0, checks = 0;
  logic [1:0] tb_mem [256];
  logic [1:0] exp_q [$];
  logic [1:0] exp_v, held;
  logic stalled = 0;

  always #5 clk = ~clk;

  lut_neuron_stream dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_perr_inj(cfg_perr_inj),
    .init_busy(init_busy), .err_parity(err_parity)
  );

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got out_data=%0d, expected no beat", out_data);
      end else begin
        exp_v = exp_q.pop_front();
        if (out_data !== exp_v) begin
          errors++;
          $display("FAIL sb_data: got %0d, expected %0d", out_data, exp_v);
        end
      end
    end
    if (rst_n && out_valid && !out_ready) begin
      if (stalled) begin
        checks++;
        if (out_data !== held) begin
          errors++;
          $display("FAIL stall_hold: got %0d, expected %0d", out_data, held);
        end
      end
      stalled = 1;
      held = out_data;
    end else stalled = 0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_model();
    foreach (tb_mem[i]) tb_mem[i] = 2'b00;
  endtask

  task automatic wait_init();
    int n = 0;
    bit rdy = 0;
    @(negedge clk);
    while (init_busy && n < 1000) begin
      n++;
      if (in_ready) rdy = 1;
      @(negedge clk);
    end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL init_len: got %0d busy cycles, expected 256", n);
    end
    checks++;
    if (rdy) begin
      errors++;
      $display("FAIL init_ready: got in_ready=1 during init, expected 0");
    end
    clear_model();
    tick();
  endtask

  task automatic send(input logic [7:0] a);
    int n = 0;
    in_valid = 1;
    in_data = a;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=0 for addr %0h, expected 1", a);
    end
    exp_q.push_back(tb_mem[a]);
    tick();
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      n++;
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d beats pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [1:0] d, input logic inj);
    cfg_we = 1;
    cfg_addr = a;
    cfg_data = d;
    cfg_perr_inj = inj;
    tick();
    tb_mem[a] = d;
    cfg_we = 0;
    cfg_perr_inj = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) tick();
    @(negedge clk);
    checks += 5;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, expected 0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
    if (out_data !== 2'b00) begin errors++; $display("FAIL rst_out_data: got %0d, expected 0", out_data); end
    if (init_busy !== 1'b1) begin errors++; $display("FAIL rst_init_busy: got %b, expected 1", init_busy); end
    if (err_parity !== 1'b0) begin errors++; $display("FAIL rst_err_parity: got %b, expected 0", err_parity); end
    tick();
    rst_n = 1;
    wait_init();
  endtask

  task automatic test_latency();
    in_valid = 1;
    in_data = 8'hA5;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_ready: got %b, expected 1", in_ready); end
    exp_q.push_back(tb_mem[8'hA5]);
    tick();
    in_valid = 0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early: got out_valid=%b one cycle after accept, expected 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: got out_valid=%b two cycles after accept, expected 1", out_valid); end
    tick();
    drain();
  endtask

  task automatic test_cfg_lookup();
    cfg_write(8'h10, 2'b10, 0);
    send(8'h10);
    send(8'h11);
    drain();
  endtask

  task automatic test_back_to_back();
    cfg_write(8'h00, 2'd1, 0);
    cfg_write(8'h01, 2'd2, 0);
    cfg_write(8'h02, 2'd3, 0);
    fork
      begin send(8'h00); send(8'h01); send(8'h02); send(8'h00); end
      begin tick(); tick(); out_ready = 0; repeat (5) tick(); out_ready = 1; end
    join
    drain();
  endtask

  task automatic test_same_cycle();
    cfg_we = 1;
    cfg_addr = 8'h33;
    cfg_data = 2'b01;
    in_valid = 1;
    in_data = 8'h33;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rbw_ready: got %b, expected 1", in_ready); end
    exp_q.push_back(tb_mem[8'h33]);
    tick();
    tb_mem[8'h33] = 2'b01;
    cfg_we = 0;
    in_valid = 0;
    send(8'h33);
    drain();
  endtask

  task automatic test_reset_mid();
    cfg_write(8'h10, 2'b10, 0);
    send(8'h10);
    send(8'h10);
    rst_n = 0;
    tick();
    exp_q.delete();
    @(negedge clk);
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b, expected 0", out_valid); end
    if (init_busy !== 1'b1) begin errors++; $display("FAIL mid_rst_busy: got %b, expected 1", init_busy); end
    tick();
    rst_n = 1;
    wait_init();
    send(8'h10);
    drain();
  endtask

  task automatic test_parity();
`ifdef LUT_PARITY_EN
    cfg_write(8'h07, 2'b11, 1);
    send(8'h07);
    drain();
    checks++;
    if (err_parity !== 1'b1) begin errors++; $display("FAIL par_set: got %b, expected 1", err_parity); end
    cfg_write(8'h08, 2'b01, 0);
    send(8'h08);
    send(8'h00);
    drain();
    checks++;
    if (err_parity !== 1'b1) begin errors++; $display("FAIL par_sticky: got %b, expected 1", err_parity); end
    rst_n = 0;
    tick();
    @(negedge clk);
    checks++;
    if (err_parity !== 1'b0) begin errors++; $display("FAIL par_clear: got %b, expected 0", err_parity); end
    tick();
    rst_n = 1;
    wait_init();
`else
    cfg_write(8'h07, 2'b11, 1);
    send(8'h07);
    drain();
    checks++;
    if (err_parity !== 1'b0) begin errors++; $display("FAIL par_tied: got %b, expected 0", err_parity); end
`endif
  endtask

  initial begin
    clear_model();
    #1;
    test_reset();
    test_latency();
    test_cfg_lookup();
    test_back_to_back();
    test_same_cycle();
    test_reset_mid();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lut_neuron_stream.md
Name: lut_neuron_stream

Overview:
- Parametrised, runtime-programmable successor to the fixed distributed-ROM LUT neurons in the LogicNets layers.
- Maps a packed FAN_IN×IN_BITS activation vector to an OUT_BITS activation through a writable truth table.
- Input and output are valid/ready streams; the table is cleared by hardware after reset and then loaded through a config port.
- Sits inside layer wrappers, so retrained layers reuse one bitstream.

Parameters:
- FAN_IN, 4, number of input activations per neuron.
- IN_BITS, 2, bits per input activation.
- OUT_BITS, 2, bits per output activation.
- INIT_VAL, 0, value written to every table entry during post-reset clear (OUT_BITS wide).
- Derived: ADDR_W = FAN_IN*IN_BITS; DEPTH = 2**ADDR_W. Default is 8 and 256.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts input beat.
- in_data  in  ADDR_W  packed inputs; input i = in_data[i*IN_BITS +: IN_BITS]; used directly as table address.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  OUT_BITS  table[in_data].
- cfg_we  in  1  table write strobe.
- cfg_addr  in  ADDR_W  write address.
- cfg_data  in  OUT_BITS  write data.
- cfg_perr_inj  in  1  with cfg_we, store the entry with inverted parity (LUT_PARITY_EN only; ignored otherwise).
- init_busy  out  1  hardware clear in progress.
- err_parity  out  1  sticky parity error flag.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, init_busy=1, err_parity=0. The FSM enters INIT with clr_cnt=0.
- FSM has two states, INIT and RUN.
- INIT:
  - Writes INIT_VAL to table[clr_cnt] each cycle and increments clr_cnt.
  - Ignores cfg_we. Holds in_ready=0.
  - After writing entry DEPTH-1, moves to RUN and deasserts init_busy on the next edge. Duration is exactly DEPTH cycles after reset release.
- RUN:
  - adv = !s1_valid || (!s2_valid || out_ready) for stage 1; stage 2 advances when !s2_valid || out_ready.
  - in_ready = RUN && stage-1 advance condition. This is purely combinational from registered state and out_ready, with no in_valid→in_ready path.
- Pipeline and latency:
  - Stage 1 registers the address on accept.
  - Stage 2 registers the synchronous table read.
  - Latency from accept to out_valid is 2 cycles. Throughput is 1 beat per cycle while out_ready=1.
- Backpressure:
  - With out_ready=0, out_valid/out_data hold stable. Stage 1 holds its beat and its read data is not lost; a bubble-free restart is required.
  - No beat is dropped or duplicated, and order is preserved.
- Config writes:
  - Accepted in RUN on any cycle, independent of stream traffic.
  - A write and a stage-1 read of the same address in the same cycle return the old value (read-before-write). Later lookups see the new value.
- Reset mid-operation (rst_n=0 in any state):
  - Flushes both stages and drops in-flight beats.
  - Restarts INIT from clr_cnt=0, overwriting all programmed entries.
- Width rules: there is no arithmetic on data. clr_cnt is ADDR_W+1 bits wide so DEPTH is reachable without wrap.

Optional Feature:
- Macro: LUT_PARITY_EN.
- Defined:
  - Each entry stores OUT_BITS+1 bits, with even parity over the data. cfg_perr_inj inverts the stored parity bit.
  - Stage 2 checks parity on every accepted read. On mismatch, err_parity sets and stays 1 until rst_n. out_data still carries the stored data.
- Undefined:
  - Entries are OUT_BITS wide, err_parity is tied 0, and cfg_perr_inj is unused.

Decomposition:
- Shared package lut_neuron_pkg:
  - fsm_state_t enum {INIT, RUN}.
  - Function addr_w(FAN_IN, IN_BITS).
  - Parity function.
- One sub-module, lut_neuron_tbl: simple dual-port RAM with one write port and one registered read port with read enable, width OUT_BITS(+1), distributed ROM style.
- FSM, pipeline and handshake stay in lut_neuron_stream.

Test Plan:
- Reset release with defaults → init_busy=1 for exactly 256 cycles and in_ready=0 throughout; then any in_data (e.g. 8'hA5) returns out_data=2'b00 two cycles after accept.
- Write cfg_addr=8'h10, cfg_data=2'b10, then send in_data=8'h10 → out_valid at +2 with out_data=2'b10; in_data=8'h11 → 2'b00.
- Program addrs 0..2 = 1,2,3; stream 0,1,2,0 back-to-back with out_ready low for 5 cycles mid-stream → outputs 1,2,3,1 in order, none lost, out_data stable while stalled.
- Same cycle: cfg_we to 8'h33 with 2'b01 and accept in_data=8'h33 (old 2'b00) → returns 2'b00; next lookup of 8'h33 returns 2'b01.
- Assert rst_n=0 for 1 cycle mid-stream after programming 8'h10=2'b10 → out_valid=0 next cycle, INIT reruns for 256 cycles, then 8'h10 reads 2'b00.
- LUT_PARITY_EN: write 8'h07=2'b11 with cfg_perr_inj=1, then look up 8'h07 → out_data=2'b11 and err_parity=1, still 1 after further clean lookups until reset.
